// File: rtl/operand_fetch_rf.sv
// Operand-fetch stage: register file, write-back mux, pending-write
// scoreboard with RAW/WAW stalls and a registered operand bundle.
module operand_fetch_rf #(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 32,
  parameter int ADDR_W      = $clog2(NUM_REGS),
  parameter int ZERO_REG    = 1,
  parameter int STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   issue_valid,
  output logic                   issue_ready,
  input  logic [ADDR_W-1:0]      rs1_addr,
  input  logic [ADDR_W-1:0]      rs2_addr,
  input  logic [ADDR_W-1:0]      rd_addr,
  input  logic                   rd_we,
  output logic                   op_valid,
  input  logic                   op_ready,
  output logic [DATA_W-1:0]      rs1_data,
  output logic [DATA_W-1:0]      rs2_data,
  output logic [ADDR_W-1:0]      op_rd_addr,
  output logic                   op_rd_we,
  input  logic                   wb_valid,
  input  logic [ADDR_W-1:0]      wb_addr,
  input  logic                   wb_mem_to_reg,
  input  logic [DATA_W-1:0]      wb_mem_data,
  input  logic [DATA_W-1:0]      wb_alu_result,
  output logic [DATA_W-1:0]      wb_data,
  output logic [NUM_REGS-1:0]    busy_vec,
  output logic [STALL_CNT_W-1:0] stall_count
);

  localparam logic ZR = (ZERO_REG != 0);
  localparam logic [NUM_REGS-1:0] ONE =
    {{(NUM_REGS-1){1'b0}}, 1'b1};

  logic [DATA_W-1:0]   regs [NUM_REGS];
  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] wb_hit;
  logic [NUM_REGS-1:0] rdy_vec;
  logic [NUM_REGS-1:0] set_vec;
  logic [DATA_W-1:0]   rs1_val;
  logic [DATA_W-1:0]   rs2_val;
  logic                hazard;
  logic                accept;
  logic                wb_wr;

  assign busy_vec = busy;

  always_comb begin
    wb_data = '0;
    if (wb_valid)
      wb_data = wb_mem_to_reg ? wb_mem_data : wb_alu_result;
  end

  assign wb_hit = wb_valid ? (ONE << wb_addr) : '0;
  assign wb_wr  = wb_valid && !(ZR && wb_addr == '0);

  // A source is ready if nothing is pending or it retires right now.
  always_comb begin
    rdy_vec = ~busy | wb_hit;
    if (ZR)
      rdy_vec[0] = 1'b1;
  end

  always_comb begin
    rs1_val = regs[rs1_addr];
    if (wb_valid && wb_addr == rs1_addr)
      rs1_val = wb_data;
    if (ZR && rs1_addr == '0)
      rs1_val = '0;
  end

  always_comb begin
    rs2_val = regs[rs2_addr];
    if (wb_valid && wb_addr == rs2_addr)
      rs2_val = wb_data;
    if (ZR && rs2_addr == '0)
      rs2_val = '0;
  end

  assign hazard = issue_valid &&
                  (!rdy_vec[rs1_addr] ||
                   !rdy_vec[rs2_addr] ||
                   (rd_we && !rdy_vec[rd_addr]));

  assign issue_ready = !hazard && (!op_valid || op_ready);
  assign accept      = issue_valid && issue_ready;

  always_comb begin
    set_vec = '0;
    if (accept && rd_we && (rd_addr != '0 || !ZR))
      set_vec = ONE << rd_addr;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_REGS; i++)
        regs[i] <= '0;
    end else if (wb_wr) begin
      regs[wb_addr] <= wb_data;
    end
  end

  // Set is applied after clear so a same-cycle reissue keeps the bit.
  always_ff @(posedge clk) begin
    if (!rst_n)
      busy <= '0;
    else
      busy <= (busy & ~wb_hit) | set_vec;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_valid   <= 1'b0;
      rs1_data   <= '0;
      rs2_data   <= '0;
      op_rd_addr <= '0;
      op_rd_we   <= 1'b0;
    end else if (accept) begin
      op_valid   <= 1'b1;
      rs1_data   <= rs1_val;
      rs2_data   <= rs2_val;
      op_rd_addr <= rd_addr;
      op_rd_we   <= rd_we;
    end else if (op_valid && op_ready) begin
      op_valid   <= 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_count <= '0;
    else if (hazard && stall_count != '1)
      stall_count <= stall_count + 1'b1;
  end

endmodule

// File: tb/tb_operand_fetch_rf.sv
// Bench for operand_fetch_rf: directed test-plan steps then random
// traffic, all checked against an array/scoreboard reference model.
module tb_operand_fetch_rf;

  localparam int SCW = 4;
  localparam int SMAX = (1 << SCW) - 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [4:0]  rs1_addr = '0;
  logic [4:0]  rs2_addr = '0;
  logic [4:0]  rd_addr = '0;
  logic        rd_we = 1'b0;
  logic        op_valid;
  logic        op_ready = 1'b1;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic [4:0]  op_rd_addr;
  logic        op_rd_we;
  logic        wb_valid = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic        wb_mem_to_reg = 1'b0;
  logic [31:0] wb_mem_data = '0;
  logic [31:0] wb_alu_result = '0;
  logic [31:0] wb_data;
  logic [31:0] busy_vec;
  logic [SCW-1:0] stall_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_regs [32];
  logic [31:0] m_busy = '0;
  logic        m_opv = 1'b0;
  logic [31:0] m_rs1 = '0;
  logic [31:0] m_rs2 = '0;
  logic [4:0]  m_rd = '0;
  logic        m_rdwe = 1'b0;
  int          m_stall = 0;

  operand_fetch_rf #(.STALL_CNT_W(SCW)) dut (
    .clk(clk), .rst_n(rst_n),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .rd_we(rd_we),
    .op_valid(op_valid), .op_ready(op_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data),
    .op_rd_addr(op_rd_addr), .op_rd_we(op_rd_we),
    .wb_valid(wb_valid), .wb_addr(wb_addr),
    .wb_mem_to_reg(wb_mem_to_reg),
    .wb_mem_data(wb_mem_data),
    .wb_alu_result(wb_alu_result),
    .wb_data(wb_data), .busy_vec(busy_vec),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic rdy(input logic [4:0] a);
    return a == 0 || !m_busy[a] || (wb_valid && wb_addr == a);
  endfunction

  function automatic logic [31:0] srcval(input logic [4:0] a,
                                         input logic [31:0] wbd);
    if (a == 0) return 32'h0;
    if (wb_valid && wb_addr == a) return wbd;
    return m_regs[a];
  endfunction

  task automatic idle();
    issue_valid = 1'b0;
    rd_we = 1'b0;
    wb_valid = 1'b0;
    wb_mem_to_reg = 1'b0;
  endtask

  task automatic issue(input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] d, input logic we);
    issue_valid = 1'b1;
    rs1_addr = a;
    rs2_addr = b;
    rd_addr = d;
    rd_we = we;
  endtask

  task automatic wb(input logic [4:0] a, input logic mem,
                    input logic [31:0] d);
    wb_valid = 1'b1;
    wb_addr = a;
    wb_mem_to_reg = mem;
    wb_mem_data = mem ? d : 32'h1234_5678;
    wb_alu_result = mem ? 32'h8765_4321 : d;
  endtask

  // One clock: comb checks before the edge, model step, then
  // registered checks just after the edge.
  task automatic cycle();
    logic [31:0] wbd, sv1, sv2;
    logic hz, ir, acc;
    #3;
    wbd = wb_valid ? (wb_mem_to_reg ? wb_mem_data : wb_alu_result)
                   : 32'h0;
    hz = issue_valid && (!rdy(rs1_addr) || !rdy(rs2_addr) ||
                         (rd_we && !rdy(rd_addr)));
    ir = !hz && (!m_opv || op_ready);
    acc = issue_valid && ir;
    sv1 = srcval(rs1_addr, wbd);
    sv2 = srcval(rs2_addr, wbd);
    if (rst_n) begin
      chk("wb_data", wb_data, wbd);
      chk("issue_ready", issue_ready, ir);
    end
    @(posedge clk);
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) m_regs[i] = '0;
      m_busy = '0; m_opv = 0; m_rs1 = '0; m_rs2 = '0;
      m_rd = '0; m_rdwe = 0; m_stall = 0;
    end else begin
      if (wb_valid && wb_addr != 0) m_regs[wb_addr] = wbd;
      if (wb_valid) m_busy[wb_addr] = 1'b0;
      if (acc && rd_we && rd_addr != 0) m_busy[rd_addr] = 1'b1;
      if (acc) begin
        m_opv = 1; m_rs1 = sv1; m_rs2 = sv2;
        m_rd = rd_addr; m_rdwe = rd_we;
      end else if (m_opv && op_ready) begin
        m_opv = 0;
      end
      if (hz && m_stall < SMAX) m_stall++;
    end
    #1;
    chk("op_valid", op_valid, m_opv);
    chk("rs1_data", rs1_data, m_rs1);
    chk("rs2_data", rs2_data, m_rs2);
    chk("op_rd_addr", op_rd_addr, m_rd);
    chk("op_rd_we", op_rd_we, m_rdwe);
    chk("busy_vec", busy_vec, m_busy);
    chk("stall_count", stall_count, m_stall);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) m_regs[i] = '0;
    cycle();
    chk("rst_busy", busy_vec, 0);
    chk("rst_opv", op_valid, 0);
    rst_n = 1'b1;

    wb(1, 0, 6); cycle();
    idle(); wb(2, 1, 5); cycle();
    idle(); issue(1, 2, 3, 1); cycle();
    chk("tp1_valid", op_valid, 1);
    chk("tp1_rs1", rs1_data, 6);
    chk("tp1_rs2", rs2_data, 5);
    chk("tp1_busy3", busy_vec[3], 1);

    idle(); issue(0, 0, 5, 1); cycle();
    idle(); issue(5, 0, 0, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("raw_stall", stall_count, 3);
    wb(5, 0, 15); cycle();
    chk("raw_rs1", rs1_data, 15);
    chk("raw_busy5", busy_vec[5], 0);

    idle(); wb(0, 1, 32'hDEAD_BEEF); cycle();
    idle(); issue(0, 0, 0, 0); cycle();
    chk("r0_rs1", rs1_data, 0);
    chk("r0_nostall", stall_count, 3);

    op_ready = 1'b0; issue(1, 2, 9, 0);
    for (int i = 0; i < 3; i++) cycle();
    chk("hold_rs1", rs1_data, 0);
    op_ready = 1'b1; cycle();
    chk("rel_valid", op_valid, 1);
    chk("rel_rs1", rs1_data, 6);

    idle(); issue(0, 0, 7, 1); cycle();
    wb(7, 0, 32'h77); cycle();
    chk("col_busy7", busy_vec[7], 1);
    idle(); issue(7, 0, 0, 0); cycle();
    wb(7, 0, 32'h99); cycle();
    chk("col_rs1", rs1_data, 32'h99);

    idle(); issue(0, 0, 12, 1); op_ready = 1'b0; cycle();
    chk("pre_rst_busy", busy_vec != 0, 1);
    rst_n = 1'b0; cycle();
    chk("mid_rst_busy", busy_vec, 0);
    chk("mid_rst_opv", op_valid, 0);
    rst_n = 1'b1; op_ready = 1'b1;

    for (int n = 0; n < 400; n++) begin
      issue_valid = 1'($urandom_range(0, 1));
      rs1_addr = 5'($urandom_range(0, 7));
      rs2_addr = 5'($urandom_range(0, 7));
      rd_addr = 5'($urandom_range(0, 7));
      rd_we = 1'($urandom_range(0, 1));
      op_ready = ($urandom_range(0, 3) != 0);
      wb_valid = 1'($urandom_range(0, 1));
      wb_addr = 5'($urandom_range(0, 7));
      wb_mem_to_reg = 1'($urandom_range(0, 1));
      wb_mem_data = $urandom;
      wb_alu_result = $urandom;
      cycle();
    end

    idle(); op_ready = 1'b1;
    rst_n = 1'b0; cycle(); rst_n = 1'b1;
    issue(0, 0, 5, 1); cycle();
    issue(5, 0, 0, 0);
    for (int i = 0; i < SMAX + 1 + 5; i++) cycle();
    chk("sat", stall_count, SMAX);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
